serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/serial_adder_full_add.sv | 29 ++
 rtl/serial_adder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e       : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_adder_full_add.sv
// One-bit full adder used as the single arithmetic slice of serial_adder.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// Built from two half-adder slices with an OR merging their carries.
module full_add (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // first half adder: x + y
  assign ha0_s = x ^ y;
  assign ha0_c = x & y;

  // second half adder: partial sum + carry in
  assign s     = ha0_s ^ ci;
  assign ha1_c = ha0_s & ci;

  assign co    = ha0_c | ha1_c;

endmodule : full_add

// File: rtl/serial_adder.sv
// Bit-serial adder: computes {cout, sum} = a + b + cin one bit per clock.
//   clk   : clock, rising edge active
//   rst_n : asynchronous active-low reset
//   start : begin an addition (sampled only in IDLE)
//   a, b  : operands, captured on the accepting edge
//   cin   : carry in, captured on the accepting edge
//   busy  : high whenever the FSM is not IDLE
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered result, held until the next completion
//   cout  : registered carry out, held like sum
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned       CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     LAST_CNT = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_s;
  logic               fa_co;

  full_add u_full_add (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // sum bits enter from the MSB side so that after WIDTH shifts
        // bit 0 of the result sits at res[0]
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // publish including the bit produced on this very edge
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder
